fp_sqrt_arbiter: RTL

Shares one multi-cycle floating-point square-root datapath between NUM_REQ requesters using round-robin arbitration.
- Latches the granted requester's IEEE-754 single operand and pulses dp_start.
- Waits for dp_done, then returns the result to the owner.
- Rejects negative operands locally without engaging the datapath.
- A watchdog aborts the datapath if dp_done never arrives.
- Sits between client blocks and the square-root controller/datapath pair.

---
 rtl/fp_sqrt_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fp_sqrt_arbiter.sv
// fp_sqrt_arbiter: round-robin front end that shares one multi-cycle
// single-precision square-root datapath between NUM_REQ requesters.
// A negative operand gets a quiet-NaN error reply without touching the
// datapath. A watchdog aborts the datapath if dp_done never arrives.
module fp_sqrt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_operand,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   dp_start,
  output logic [31:0]            dp_operand,
  output logic                   dp_abort,
  input  logic                   dp_done,
  input  logic [31:0]            dp_result
);

  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [ID_W-1:0]      cur_id_q;
  logic [ID_W-1:0]      last_grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [31:0]          rsp_data_q;
  logic                 rsp_err_q;
  logic [31:0]          dp_operand_q;
  logic                 dp_abort_q;

  // Arbitration result for the current IDLE cycle.
  logic                 grant_vld_d;
  logic [ID_W-1:0]      grant_id_d;
  logic [31:0]          grant_op_d;
  logic                 grant_neg_d;

  // Unpacked view of the operand bus and the rotated search order.
  logic [31:0]          op_arr   [NUM_REQ];
  logic [ID_W-1:0]      cand_id  [NUM_REQ];

  genvar gi;

  // cand_id[k] is the requester examined at search position k, i.e.
  // (last_grant + 1 + k) mod NUM_REQ, so position 0 is the highest priority.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign op_arr[gi] = req_operand[32*gi +: 32];
      assign sum = {1'b0, last_grant_q} + (ID_W+1)'(gi + 1);
      assign cand_id[gi] = (sum >= (ID_W+1)'(NUM_REQ))
                         ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                         : sum[ID_W-1:0];
    end
  endgenerate

  // Pick the first pending requester in rotated order (lowest position wins).
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_id[k]]) begin
        grant_vld_d = 1'b1;
        grant_id_d  = cand_id[k];
      end
    end
  end

  // Winner's operand; -0.0 is not negative for rejection purposes.
  always_comb begin
    grant_op_d  = op_arr[grant_id_d];
    grant_neg_d = grant_op_d[31] & (|grant_op_d[30:0]);
  end

  // Control FSM with registered handshake, data and abort outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      ack_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      dp_operand_q <= '0;
      dp_abort_q   <= 1'b0;
    end else begin
      ack_q      <= '0;
      dp_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            cur_id_q     <= grant_id_d;
            dp_operand_q <= grant_op_d;
            ack_q        <= NUM_REQ'(1) << grant_id_d;
            if (grant_neg_d) begin
              rsp_data_q <= QNAN;
              rsp_err_q  <= 1'b1;
              state_q    <= RESP;
            end else begin
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            rsp_data_q <= dp_result;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_data_q <= QNAN;
            rsp_err_q  <= 1'b1;
            dp_abort_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          last_grant_q <= cur_id_q;
          rsp_err_q    <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response strobe is decoded from the state register and owner id.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_q == RESP) && (cur_id_q == ID_W'(gi));
    end
  endgenerate

  assign ack        = ack_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign dp_start   = (state_q == ISSUE);
  assign dp_operand = dp_operand_q;
  assign dp_abort   = dp_abort_q;

endmodule
